io_out_buffer: RTL and testbench
================================

Name: io_out_buffer

Overview:
Parametrised successor to the CPU's single-register 8-bit output path. Captures every value the CPU presents with outFlag into a first-word-fall-through FIFO and streams it out on a valid/ready interface. A run/drain/done state machine driven by startIO and endFlag signals completion once the buffer is empty after the program ends. Sits between the CPU output port and the board-level display/UART consumer.

Parameters:
DATAWIDTH, 8, width of each captured output word
DEPTH, 16, FIFO entries; power of two, at least 2
ADDRESSWIDTH, 4, log2(DEPTH); pointer width

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
startIO  input  1  run enable (board switch); level-sensitive
outFlag  input  1  CPU write strobe; one word per high cycle
out  input  DATAWIDTH  CPU output data, sampled when outFlag=1
endFlag  input  1  CPU program-finished indication
dataOut  output  DATAWIDTH  head-of-FIFO word
dataValid  output  1  dataOut holds a valid word
dataReady  input  1  consumer accepts the word this cycle
full  output  1  count==DEPTH
empty  output  1  count==0
count  output  ADDRESSWIDTH+1  occupancy, 0..DEPTH
overflow  output  1  sticky: a write was dropped
done  output  1  run finished and buffer drained

Behaviour:
- One clock domain. Reset is synchronous and active-high, named clock/reset as in the rest of the CPU.
- Reset values: state=IDLE, both pointers=0, count=0, empty=1, full=0, dataValid=0, overflow=0, done=0, dataOut=0.
- States:
  - IDLE: writes ignored; dataValid=0. startIO=1 moves to RUN next cycle.
  - RUN: push when outFlag=1 and the push is accepted. endFlag=1 moves to DRAIN; a push in that same cycle is still accepted.
  - DRAIN: pushes ignored; pops continue. Moves to DONE in the cycle after count reaches 0. If endFlag arrives with an empty FIFO, DRAIN lasts exactly 1 cycle.
  - DONE: done=1; pushes ignored. Holds until startIO=0.
- startIO=0 in RUN, DRAIN or DONE: return to IDLE next cycle. Pointers and count are flushed to 0; overflow and done are cleared.
- Pop:
  - Occurs when dataValid=1 and dataReady=1.
  - dataValid = !empty and state is RUN or DRAIN.
  - dataOut is always mem[rdPtr], first-word-fall-through.
- Push accept rule: accepted if !full, or if a pop occurs in the same cycle (full with simultaneous push and pop leaves count unchanged).
- Overflow: a rejected push in RUN sets overflow. It stays set until reset or IDLE entry; no wrap-over of existing data.
- Latency: a word pushed in cycle N appears on dataOut with dataValid=1 in cycle N+1 when the FIFO was empty.
- Pointers: wrap modulo DEPTH.
- Count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- full and empty are derived from the registered count.
- Reset asserted mid-operation overrides everything in that cycle.

Test Plan:
- Reset, startIO=1; push 0x11,0x22,0x33 on consecutive cycles with dataReady=0 -> count=3, dataOut=0x11, dataValid=1; then dataReady=1 for 3 cycles -> 0x11,0x22,0x33 in order, empty=1.
- DEPTH=16: push 17 words 0x00..0x10 with dataReady=0 -> full=1 after the 16th, overflow=1 after the 17th, count=16; drain yields 0x00..0x0F only.
- Full FIFO with outFlag=1, dataReady=1 in the same cycle -> count stays 16, new word appended, overflow stays 0.
- Push 0xA5 together with endFlag=1, 2 words already queued -> state DRAIN; 3 words drain; done=1 in the cycle after empty; outFlag afterwards ignored.
- In DONE, or mid-RUN with count=5, drop startIO to 0 -> next cycle count=0, done=0, overflow=0, dataValid=0, state IDLE.
- Assert reset with count=7 and overflow=1 -> next cycle all outputs at their reset values.

Source files
------------

// File: rtl/io_out_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : io_out_buffer
//  Description : Output path between the CPU output port and the board-level
//                display/UART consumer. Every word the CPU presents with
//                outFlag is captured into a first-word-fall-through FIFO and
//                streamed out on a valid/ready interface. A run/drain/done
//                state machine, driven by startIO and endFlag, reports
//                completion once the buffer has emptied after program end.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock      in   system clock, rising-edge
//    reset      in   synchronous active-high reset
//    startIO    in   run enable (level); low flushes the buffer
//    outFlag    in   CPU write strobe, one word per high cycle
//    out        in   CPU output data, sampled when outFlag=1
//    endFlag    in   CPU program-finished indication
//    dataOut    out  head-of-FIFO word
//    dataValid  out  dataOut holds a valid word
//    dataReady  in   consumer accepts the word this cycle
//    full       out  count == DEPTH
//    empty      out  count == 0
//    count      out  occupancy, 0..DEPTH
//    overflow   out  sticky: a write was dropped
//    done       out  run finished and buffer drained
// ============================================================================
module io_out_buffer #(
    parameter int DATAWIDTH    = 8,
    parameter int DEPTH        = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    startIO,
    input  logic                    outFlag,
    input  logic [DATAWIDTH-1:0]    out,
    input  logic                    endFlag,
    output logic [DATAWIDTH-1:0]    dataOut,
    output logic                    dataValid,
    input  logic                    dataReady,
    output logic                    full,
    output logic                    empty,
    output logic [ADDRESSWIDTH:0]   count,
    output logic                    overflow,
    output logic                    done
);

    localparam logic [ADDRESSWIDTH-1:0] c_ptr_one  = ADDRESSWIDTH'(1);
    localparam logic [ADDRESSWIDTH:0]   c_cnt_one  = (ADDRESSWIDTH+1)'(1);
    localparam logic [ADDRESSWIDTH:0]   c_cnt_full = (ADDRESSWIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATAWIDTH-1:0]    r_mem [DEPTH];
    logic [ADDRESSWIDTH-1:0] r_wr_ptr;
    logic [ADDRESSWIDTH-1:0] r_rd_ptr;
    logic [ADDRESSWIDTH:0]   r_count;
    logic                    r_overflow;

    logic w_flush;
    logic w_pop;
    logic w_push_req;
    logic w_push;

    // Status flags come straight from the registered occupancy.
    assign empty     = (r_count == '0);
    assign full      = (r_count == c_cnt_full);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign done      = (r_state == S_DONE);
    assign dataOut   = r_mem[r_rd_ptr];
    assign dataValid = !empty && ((r_state == S_RUN) || (r_state == S_DRAIN));

    // Dropping startIO aborts the run from any state and empties the buffer.
    assign w_flush    = !startIO;
    assign w_pop      = dataValid && dataReady;
    assign w_push_req = (r_state == S_RUN) && outFlag;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!full || w_pop);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (startIO) w_next_state = S_RUN;
            end
            S_RUN: begin
                if (w_flush)      w_next_state = S_IDLE;
                else if (endFlag) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                // Leave only once the registered count has reached zero, so an
                // empty buffer at program end still spends one cycle here.
                if (w_flush)    w_next_state = S_IDLE;
                else if (empty) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (w_flush) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Storage is cleared on reset so dataOut reads zero afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= out;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            // Rejected words are dropped; existing contents are never overwritten.
            if (w_push_req && !w_push) r_overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_out_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_io_out_buffer
//  Description : Self-checking bench for io_out_buffer. Vector records hold
//                stimulus plus the expected post-edge status; pushed words go
//                into a scoreboard queue and are compared on each handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_out_buffer;

    logic       clock;
    logic       reset;
    logic       startIO;
    logic       outFlag;
    logic [7:0] out;
    logic       endFlag;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       dataReady;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb[$];

    typedef struct {
        bit       start;
        bit       wr;
        bit [7:0] data;
        bit       endf;
        bit       rdy;
        bit       exp_push;
        int       exp_count;
        bit       exp_valid;
        bit       exp_ovf;
        bit       exp_done;
    } vec_t;

    io_out_buffer #(
        .DATAWIDTH    (8),
        .DEPTH        (16),
        .ADDRESSWIDTH (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .startIO   (startIO),
        .outFlag   (outFlag),
        .out       (out),
        .endFlag   (endFlag),
        .dataOut   (dataOut),
        .dataValid (dataValid),
        .dataReady (dataReady),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .done      (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(bit s, bit w, bit [7:0] d, bit e, bit r,
                                bit p, int c, bit v, bit o, bit dn);
        vec_t x;
        x.start = s; x.wr = w; x.data = d; x.endf = e; x.rdy = r;
        x.exp_push = p; x.exp_count = c; x.exp_valid = v;
        x.exp_ovf = o; x.exp_done = dn;
        return x;
    endfunction

    // Drive one cycle, score any handshake, then check the post-edge status.
    task automatic apply(input vec_t v);
        logic [7:0] exp_word;
        startIO   = v.start;
        outFlag   = v.wr;
        out       = v.data;
        endFlag   = v.endf;
        dataReady = v.rdy;
        @(negedge clock);
        if (dataValid && dataReady) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 32'd1, 32'd0);
            end else begin
                exp_word = sb.pop_front();
                chk("pop_data", dataOut, exp_word);
            end
        end
        if (v.exp_push) sb.push_back(v.data);
        if (!v.start) sb.delete();
        @(posedge clock);
        #1;
        chk("count",    count,     v.exp_count);
        chk("empty",    empty,     v.exp_count == 0);
        chk("full",     full,      v.exp_count == 16);
        chk("valid",    dataValid, v.exp_valid);
        chk("overflow", overflow,  v.exp_ovf);
        chk("done",     done,      v.exp_done);
        if (v.exp_valid && sb.size() > 0) chk("head", dataOut, sb[0]);
    endtask

    task automatic flush_start();
        apply(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Push n words from an empty running buffer with the consumer stalled.
    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            apply(mk(1, 1, base + 8'(i), 0, 0, i < 16, (i < 16) ? i + 1 : 16,
                     1, i >= 16, 0));
        end
    endtask

    task automatic drain(input int n, input int c0, input bit ovf);
        for (int i = 0; i < n; i++) begin
            apply(mk(1, 0, 8'h00, 0, 1, 0, c0 - i - 1, (c0 - i - 1) > 0, ovf, 0));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"},    count,     32'd0);
        chk({tag, "_empty"},    empty,     32'd1);
        chk({tag, "_full"},     full,      32'd0);
        chk({tag, "_valid"},    dataValid, 32'd0);
        chk({tag, "_overflow"}, overflow,  32'd0);
        chk({tag, "_done"},     done,      32'd0);
        chk({tag, "_dataout"},  dataOut,   32'd0);
    endtask

    vec_t t1[7];
    vec_t t4[14];

    initial begin
        // Basic order: three pushes stalled, then three pops.
        t1[0] = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        t1[1] = mk(1, 1, 8'h11, 0, 0, 1, 1, 1, 0, 0);
        t1[2] = mk(1, 1, 8'h22, 0, 0, 1, 2, 1, 0, 0);
        t1[3] = mk(1, 1, 8'h33, 0, 0, 1, 3, 1, 0, 0);
        t1[4] = mk(1, 0, 8'h00, 0, 1, 0, 2, 1, 0, 0);
        t1[5] = mk(1, 0, 8'h00, 0, 1, 0, 1, 1, 0, 0);
        t1[6] = mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0);

        // End of program with a push in the same cycle, drain, done, abort,
        // then end with an empty buffer and writes while idle.
        t4[0]  = mk(1, 1, 8'h01, 0, 0, 1, 1, 1, 0, 0);
        t4[1]  = mk(1, 1, 8'h02, 0, 0, 1, 2, 1, 0, 0);
        t4[2]  = mk(1, 1, 8'hA5, 1, 0, 1, 3, 1, 0, 0);
        t4[3]  = mk(1, 1, 8'h77, 0, 1, 0, 2, 1, 0, 0);
        t4[4]  = mk(1, 1, 8'h78, 0, 1, 0, 1, 1, 0, 0);
        t4[5]  = mk(1, 1, 8'h79, 0, 1, 0, 0, 0, 0, 0);
        t4[6]  = mk(1, 1, 8'h7A, 0, 1, 0, 0, 0, 0, 1);
        t4[7]  = mk(1, 1, 8'h7B, 0, 1, 0, 0, 0, 0, 1);
        t4[8]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        t4[9]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        t4[10] = mk(1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        t4[11] = mk(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        t4[12] = mk(0, 1, 8'h55, 0, 0, 0, 0, 0, 0, 0);
        t4[13] = mk(0, 1, 8'h56, 0, 0, 0, 0, 0, 0, 0);

        reset     = 1'b1;
        startIO   = 1'b0;
        outFlag   = 1'b0;
        out       = 8'h00;
        endFlag   = 1'b0;
        dataReady = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        foreach (t1[i]) apply(t1[i]);

        // Overflow: 17 pushes into 16 entries, only the first 16 survive.
        flush_start();
        fill(17, 8'h00);
        drain(16, 16, 1);

        // Full buffer with simultaneous push and pop.
        flush_start();
        fill(16, 8'h40);
        apply(mk(1, 1, 8'hEE, 0, 1, 1, 16, 1, 0, 0));
        drain(16, 16, 0);

        flush_start();
        foreach (t4[i]) apply(t4[i]);

        // Abort mid-run with five words queued.
        flush_start();
        fill(5, 8'h20);
        apply(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        // Reset with seven words queued and overflow set.
        flush_start();
        fill(17, 8'h80);
        drain(9, 16, 1);
        reset     = 1'b1;
        startIO   = 1'b1;
        outFlag   = 1'b1;
        out       = 8'hFF;
        dataReady = 1'b1;
        @(posedge clock);
        #1;
        check_reset_values("midreset");
        sb.delete();
        reset     = 1'b0;
        outFlag   = 1'b0;
        dataReady = 1'b0;
        startIO   = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
